// File: rtl/ram_stream_reader.sv
// Read-side sequencer for dual_port_ram: streams a contiguous address range
// (base, length) from the combinational RAM read port onto a valid/ready stream.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    fetch, hs;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    // Fetch whenever the output slot is empty or being emptied this edge.
    fetch   = (state_q == S_RUN) && (!valid_q || ready_i) && !abort_i;
    hs      = valid_q && ready_i;

    if (hs) valid_d = 1'b0;
    if (fetch) begin
      data_d  = read_data_i;
      valid_d = 1'b1;
      last_d  = (rem_q == LEN_WIDTH'(1));
      addr_d  = addr_q + ADDR_WIDTH'(1);
      rem_d   = rem_q - LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = length_i;
          state_d = (length_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else if (fetch && rem_q == LEN_WIDTH'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else if (hs && last_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // busy/done are pure decodes of the registered state.
  assign read_addr_o = addr_q;
  assign read_en_o   = fetch;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader: a RAM array feeds the DUT and the
// expected stream is computed as mem[(base+k) mod 1024] for k in 0..len-1.
module tb_ram_stream_reader;
  localparam int DW = 32, AW = 10, LW = 11, MEM = 1024;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b1;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] length_i = '0;
  logic [AW-1:0] read_addr_o;
  logic          read_en_o;
  logic [DW-1:0] read_data_i, data_o;
  logic          valid_o, last_o, busy_o, done_o;

  logic [DW-1:0] mem [MEM];
  int n_chk = 0, n_pass = 0;

  assign read_data_i = mem[read_addr_o];

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .length_i(length_i),
    .read_addr_o(read_addr_o), .read_en_o(read_en_o), .read_data_i(read_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // mode 0: ready always 1; 1: ready pattern 1,0,0 repeating; 2: random ready.
  // abort_at >= 0 raises abort_i once that many handshakes have completed.
  task automatic xfer(input int base, input int len, input int mode, input int abort_at);
    int hs = 0, fet = 0, c = 0, done_cyc, dones = 0;
    bit stall = 0, fin = 0, ab = 0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    done_cyc = (len == 0) ? 0 : -1;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = AW'(base); length_i = LW'(len);
    while (!fin) begin
      @(negedge clk);
      // A start with different parameters mid-transfer must be ignored.
      start_i = (c == 2);
      if (c == 2) begin base_addr_i = AW'(base + 333); length_i = LW'(7); end
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (c % 3 == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      abort_i = (abort_at >= 0 && hs == abort_at && !ab);
      #1;
      if (ab) begin
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_nodone", dones, 0);
        fin = 1;
      end else begin
        if (c == 0) chk("lat_c0_valid", valid_o, 0);
        if (c == 1 && len > 0) chk("lat_c1_valid", valid_o, 1);
        if (read_en_o) begin
          chk("raddr", read_addr_o, (base + fet) % MEM);
          fet++;
        end
        if (stall) begin
          chk("stall_data", data_o, pd);
          chk("stall_last", last_o, pl);
        end
        if (valid_o && ready_i && !abort_i) begin
          if (hs < len) begin
            chk("data", data_o, mem[(base + hs) % MEM]);
            chk("last", last_o, (hs == len - 1));
          end else chk("extra_word", 1, 0);
          hs++;
          if (hs == len) done_cyc = c + 1;
        end
        if (done_o) begin
          chk("done_time", c, done_cyc);
          dones++;
        end
        if (done_cyc >= 0 && c == done_cyc + 1) begin
          chk("end_busy", busy_o, 0);
          chk("end_dones", dones, 1);
          chk("end_hs", hs, len);
          fin = 1;
        end
        if (abort_i) ab = 1;
      end
      stall = valid_o && !ready_i; pd = data_o; pl = last_o;
      c++;
      if (!fin && c > len * 4 + 30) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
    end
    abort_i = 1'b0; start_i = 1'b0; ready_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) mem[i] = DW'(i + 100);
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_raddr", read_addr_o, 0);
    @(negedge clk); rst = 1'b0;

    xfer(4, 3, 0, -1);
    xfer(1022, 4, 0, -1);
    xfer(10, 8, 1, -1);
    xfer(50, 0, 0, -1);
    xfer(100, 16, 0, 5);
    xfer(7, 5, 0, -1);

    // Asynchronous reset between edges mid-stream.
    @(negedge clk); start_i = 1'b1; base_addr_i = AW'(20); length_i = LW'(10);
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rden", read_en_o, 0);
    chk("mid_rst_raddr", read_addr_o, 0);
    @(negedge clk); rst = 1'b0;
    xfer(4, 3, 0, -1);

    for (int i = 0; i < MEM; i++) mem[i] = $urandom;
    for (int k = 0; k < 14; k++) begin
      int ab_at;
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      xfer(int'($urandom_range(0, MEM - 1)), int'($urandom_range(1, 40)), 2, ab_at);
    end
    xfer(1000, 1030, 0, -1);
    xfer(int'($urandom_range(0, MEM - 1)), 30, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
